// File: rtl/ase_pkg.sv
// ---------------------------------------------------------------------------
// ase_pkg
// Shared types and constants for the ASE UMsg engine: CCI-P RX header
// layout, UMsg slot state machine encoding, per-slot state record and a
// helper that builds the RX0 UMsg header.
// Ports: none (package).
// ---------------------------------------------------------------------------

// Delay timer width normally provided by platform.vh; a default is supplied
// here so the package elaborates stand-alone.
`ifndef UMSG_DELAY_TIMER_LOG2
`define UMSG_DELAY_TIMER_LOG2 4
`endif

package ase_pkg;

    localparam int UMSG_DELAY_TIMER_LOG2 = `UMSG_DELAY_TIMER_LOG2;

    localparam int CCIP_DATA_WIDTH    = 512;
    localparam int CCIP_RX_HDR_WIDTH  = 28;
    localparam int CCIP_UMSG_BITINDEX = 12;

    localparam logic [3:0] CCIP_RX0_UMSG = 4'h4;

    // RX0 response header, MSB first; totals CCIP_RX_HDR_WIDTH bits.
    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  clnum;
        logic [3:0]  resptype;
        logic [15:0] mdata;
    } RxHdr_t;

    typedef enum logic [2:0] {
        UMsg_Idle          = 3'd0,
        UMsg_ChangeOccured = 3'd1,
        UMsg_SendHint      = 3'd2,
        UMsg_Waiting       = 3'd3,
        UMsg_SendData      = 3'd4
    } UMsg_StateEnum;

    typedef logic [UMSG_DELAY_TIMER_LOG2-1:0] umsg_timer_t;

    // Per-slot record: FSM state, dwell timers, current line data and the
    // last line actually emitted.
    typedef struct packed {
        UMsg_StateEnum                state;
        umsg_timer_t                  hint_timer;
        umsg_timer_t                  data_timer;
        logic [CCIP_DATA_WIDTH-1:0]   data;
        logic [CCIP_DATA_WIDTH-1:0]   data_q;
    } umsg_t;

    // Header for a UMsg beat: slot number in mdata[4:0], hint flag in the
    // UMsg bit, everything else zero.
    function automatic RxHdr_t umsg_hdr(input logic [4:0] slot, input logic is_hint);
        RxHdr_t h;
        h = '0;
        h.resptype = CCIP_RX0_UMSG;
        h.mdata[4:0] = slot;
        h.mdata[CCIP_UMSG_BITINDEX] = is_hint;
        return h;
    endfunction

endpackage

// File: rtl/ase_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ase_rr_arbiter
// Round-robin arbiter with one-hot grant. The search starts at the pointer
// and wraps; the pointer moves past the granted requester whenever a grant
// is issued. No grant is issued while en_i is low.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : request vector
//   en_i       : advance enable; a grant is only issued (and taken) when high
//   gnt_o      : one-hot grant vector
// ---------------------------------------------------------------------------
module ase_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    // First pass covers requesters at or above the pointer, second pass
    // wraps around to the ones below it.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && en_i && req_i[i] && (PTR_W'(i) >= ptr_q)) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && en_i && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ase_umsg_engine.sv
// ---------------------------------------------------------------------------
// ase_umsg_engine
// UMsg engine: each slot tracks writes to its UMsg line, optionally emits a
// hint beat, waits a dwell time and then emits the line data on RX0. Writes
// to a busy slot coalesce into the pending beat. Slots share one output
// register through a round-robin arbiter.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   umsg_wr_valid    : UMsg line write strobe
//   umsg_wr_id       : target slot
//   umsg_wr_data     : line data
//   umsg_hint_en     : per-slot hint enable
//   umsg_out_valid   : RX0 UMsg beat valid
//   umsg_out_ready   : downstream accept
//   umsg_out_hdr     : RX0 header (RxHdr_t)
//   umsg_out_data    : line data, zero for hints
//   umsg_busy        : some slot is not idle
//   umsg_err         : sticky, set by a write to a nonexistent slot
// ---------------------------------------------------------------------------
module ase_umsg_engine
    import ase_pkg::*;
#(
    parameter int NUM_UMSG   = 8,
    parameter int HINT_DELAY = 2,
    parameter int DATA_DELAY = 4,
    localparam int ID_W      = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         umsg_wr_valid,
    input  logic [ID_W-1:0]              umsg_wr_id,
    input  logic [CCIP_DATA_WIDTH-1:0]   umsg_wr_data,
    input  logic [NUM_UMSG-1:0]          umsg_hint_en,
    output logic                         umsg_out_valid,
    input  logic                         umsg_out_ready,
    output logic [CCIP_RX_HDR_WIDTH-1:0] umsg_out_hdr,
    output logic [CCIP_DATA_WIDTH-1:0]   umsg_out_data,
    output logic                         umsg_busy,
    output logic                         umsg_err
);

    localparam logic [31:0] NUM_U = NUM_UMSG;

    umsg_t                      slot_q [NUM_UMSG];
    umsg_t                      slot_d [NUM_UMSG];
    logic [NUM_UMSG-1:0]        req;
    logic [NUM_UMSG-1:0]        gnt;
    logic                       grant_en;
    logic                       wr_id_ok;
    logic [4:0]                 win_slot;
    logic                       win_hint;
    logic [CCIP_DATA_WIDTH-1:0] win_data;
    logic                       busy;

    logic                       out_valid_q, out_valid_d;
    RxHdr_t                     out_hdr_q, out_hdr_d;
    logic [CCIP_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                       err_q, err_d;

    assign wr_id_ok = (32'(umsg_wr_id) < NUM_U);

    // The output register can take a new beat when empty or being drained.
    assign grant_en = !out_valid_q || umsg_out_ready;

    // A hint slot requests once its dwell timer has run out; a data slot
    // requests for as long as it sits in SendData.
    always_comb begin
        req  = '0;
        busy = 1'b0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            req[i] = (slot_q[i].state == UMsg_SendData) ||
                     ((slot_q[i].state == UMsg_SendHint) && (slot_q[i].hint_timer == '0));
            if (slot_q[i].state != UMsg_Idle) begin
                busy = 1'b1;
            end
        end
    end

    ase_rr_arbiter #(
        .N (NUM_UMSG)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .en_i  (grant_en),
        .gnt_o (gnt)
    );

    // Select the granted slot; its data is sampled before any write landing
    // in the same cycle, so a racing write goes into the next beat.
    always_comb begin
        win_slot = '0;
        win_hint = 1'b0;
        win_data = '0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            if (gnt[i]) begin
                win_slot = 5'(i);
                win_hint = (slot_q[i].state == UMsg_SendHint);
                win_data = slot_q[i].data;
            end
        end
    end

    // Per-slot FSM. A write always refreshes the slot data; it only moves
    // the state out of Idle, or back to ChangeOccured when it collides with
    // the SendData grant so the new data is not lost.
    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i].state)
                UMsg_Idle: begin
                    if (umsg_wr_valid && wr_id_ok && (umsg_wr_id == ID_W'(i))) begin
                        slot_d[i].state = UMsg_ChangeOccured;
                    end
                end
                UMsg_ChangeOccured: begin
                    if (umsg_hint_en[i]) begin
                        slot_d[i].state      = UMsg_SendHint;
                        slot_d[i].hint_timer = umsg_timer_t'(HINT_DELAY);
                    end else begin
                        slot_d[i].state      = UMsg_Waiting;
                        slot_d[i].data_timer = umsg_timer_t'(DATA_DELAY);
                    end
                end
                UMsg_SendHint: begin
                    if (slot_q[i].hint_timer != '0) begin
                        slot_d[i].hint_timer = slot_q[i].hint_timer - 1'b1;
                    end else if (gnt[i]) begin
                        slot_d[i].state      = UMsg_Waiting;
                        slot_d[i].data_timer = umsg_timer_t'(DATA_DELAY);
                    end
                end
                UMsg_Waiting: begin
                    // Leave on the cycle the timer reaches zero.
                    if (slot_q[i].data_timer <= umsg_timer_t'(1)) begin
                        slot_d[i].data_timer = '0;
                        slot_d[i].state      = UMsg_SendData;
                    end else begin
                        slot_d[i].data_timer = slot_q[i].data_timer - 1'b1;
                    end
                end
                UMsg_SendData: begin
                    if (gnt[i]) begin
                        slot_d[i].data_q = slot_q[i].data;
                        if (umsg_wr_valid && wr_id_ok && (umsg_wr_id == ID_W'(i))) begin
                            slot_d[i].state = UMsg_ChangeOccured;
                        end else begin
                            slot_d[i].state = UMsg_Idle;
                        end
                    end
                end
                default: begin
                    slot_d[i].state = UMsg_Idle;
                end
            endcase
            if (umsg_wr_valid && wr_id_ok && (umsg_wr_id == ID_W'(i))) begin
                slot_d[i].data = umsg_wr_data;
            end
        end
    end

    // Output register loads on a grant and otherwise holds until accepted.
    always_comb begin
        out_valid_d = out_valid_q;
        out_hdr_d   = out_hdr_q;
        out_data_d  = out_data_q;
        if (|gnt) begin
            out_valid_d = 1'b1;
            out_hdr_d   = umsg_hdr(win_slot, win_hint);
            out_data_d  = win_hint ? '0 : win_data;
        end else if (umsg_out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign err_d = err_q || (umsg_wr_valid && !wr_id_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                slot_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_hdr_q   <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                slot_q[i] <= slot_d[i];
            end
            out_valid_q <= out_valid_d;
            out_hdr_q   <= out_hdr_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign umsg_out_valid = out_valid_q;
    assign umsg_out_hdr   = out_hdr_q;
    assign umsg_out_data  = out_data_q;
    assign umsg_busy      = busy;
    assign umsg_err       = err_q;

endmodule

// File: doc/ase_umsg_engine.md
ASE_UMSG_ENGINE -- requirements
Module: ase_umsg_engine

Interface
REQ-001 Parameter NUM_UMSG, default 8: number of UMsg slots, 1..32.
REQ-002 Parameter HINT_DELAY, default 2: SendHint dwell cycles; SHALL be < 2**UMSG_DELAY_TIMER_LOG2.
REQ-003 Parameter DATA_DELAY, default 4: Waiting dwell cycles; SHALL be < 2**UMSG_DELAY_TIMER_LOG2.
REQ-004 clk  in  1  single clock; one clock; reset is asynchronous and active-low.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 umsg_wr_valid  in  1  UMsg line write strobe.
REQ-007 umsg_wr_id  in  $clog2(NUM_UMSG) (min 1)  target slot.
REQ-008 umsg_wr_data  in  CCIP_DATA_WIDTH  line data.
REQ-009 umsg_hint_en  in  NUM_UMSG  per-slot hint enable, sampled in ChangeOccured.
REQ-010 umsg_out_valid  out  1  RX0 UMsg beat valid.
REQ-011 umsg_out_ready  in  1  downstream RX0 mux accept.
REQ-012 umsg_out_hdr  out  CCIP_RX_HDR_WIDTH  RxHdr_t.
REQ-013 umsg_out_data  out  CCIP_DATA_WIDTH  line data; zero for hints.
REQ-014 umsg_busy  out  1  any slot not in UMsg_Idle.
REQ-015 umsg_err  out  1  sticky; set by a write with umsg_wr_id >= NUM_UMSG.

Function
REQ-016 Each slot SHALL run a UMsg_StateEnum FSM: UMsg_Idle, UMsg_ChangeOccured, UMsg_SendHint, UMsg_Waiting, UMsg_SendData.
REQ-017 Idle + write to slot: latch data, go ChangeOccured next cycle.
REQ-018 ChangeOccured: hint_en[slot]=1 -> SendHint with hint_timer=HINT_DELAY; else -> Waiting with data_timer=DATA_DELAY.
REQ-019 SendHint: decrement hint_timer each cycle while nonzero; at zero request the arbiter; on grant -> Waiting with data_timer=DATA_DELAY.
REQ-020 Waiting: decrement data_timer while nonzero; at zero -> SendData.
REQ-021 SendData: request; on grant -> Idle and data_q <= data.
REQ-022 Write to a non-Idle slot SHALL overwrite data and leave the state unchanged (coalescing); the emitted data is the slot data at grant.
REQ-023 Write to a slot in the same cycle as its SendData grant: the granted beat carries the old data; the slot SHALL go to ChangeOccured, not Idle.
REQ-024 Write with umsg_wr_id >= NUM_UMSG SHALL be dropped and set umsg_err.
REQ-025 Round-robin arbitration SHALL apply over requesting slots, pointer advancing past the granted slot; hints and data have equal priority.
REQ-026 Output register: a grant SHALL occur only when umsg_out_valid=0 or umsg_out_ready=1; the output SHALL load on the cycle after grant.
REQ-027 Output held stable while umsg_out_valid=1 and umsg_out_ready=0.
REQ-028 hdr.resptype=CCIP_RX0_UMSG; hdr.mdata[4:0]=slot; hdr.mdata[CCIP_UMSG_BITINDEX]=1 for hint, 0 for data; all other hdr fields 0.
REQ-029 Hint disabled, output free: write at cycle N -> umsg_out_valid at N+3+DATA_DELAY.
REQ-030 Hint enabled, output free: hint at N+3+HINT_DELAY; data at N+4+HINT_DELAY+DATA_DELAY.

Reset
REQ-031 On rst_n low, asynchronously: all slots Idle; timers, data and data_q zero; arbiter pointer 0; umsg_out_valid, hdr and data 0; umsg_busy 0; umsg_err 0.
REQ-032 Reset mid-operation SHALL discard pending hints and data; no beat is emitted for pre-reset writes after release.

Structure
REQ-033 umsg_t, UMsg_StateEnum, RxHdr_t, CCIP_RX0_UMSG, CCIP_UMSG_BITINDEX and CCIP_DATA_WIDTH SHALL come from ase_pkg; UMSG_DELAY_TIMER_LOG2 SHALL come from platform.vh.
REQ-034 Arbitration SHALL be a sub-module ase_rr_arbiter (parameter N; request and grant vectors; one-hot grant; advance enable).

Verification
REQ-035 Slot 3, hint off, D=4, ready=1: write 0xA5.. at N -> single data beat at N+7, mdata=0x0003, data=0xA5...
REQ-036 Slot 1, hint on, H=2, D=4: write at N -> hint at N+5 (mdata=0x1001, data=0), data at N+10.
REQ-037 Three writes to slot 0 in Waiting (values 1, 2, 3) -> exactly one data beat, value 3.
REQ-038 Slots 0, 2, 5 all reach SendData in the same cycle, ready=1 -> beats in order 0, 2, 5 on consecutive cycles; with ready=0 for 4 cycles, the first beat is held unchanged.
REQ-039 Write to slot 2 during its SendData grant -> old beat emitted, a second beat with the new data after DATA_DELAY+3.
REQ-040 NUM_UMSG=6, write id 7 -> no beat, umsg_err=1 until reset; rst_n pulsed during Waiting -> no beat, umsg_busy=0.
